spi_master_arbiter: RTL and testbench

- SPI mode-1 master (CPOL=0, CPHA=1) that shares one SPI link to the LED slave controller between two requesters.
- Each requester writes one slave register: requester 0 targets address 0 (red), requester 1 targets address 1 (blue).
- Serialises an 8-bit frame: the address bit first, then 7 data bits MSB-first.
- Provides chip-select framing, a programmable SCLK rate and round-robin arbitration.

---
 rtl/spi_master_arbiter.sv | 205 ++++++++++++++++++++
 tb/tb_spi_master_arbiter.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/spi_master_arbiter.sv
// SPI mode-1 master shared by two write requesters with round-robin arbitration.
// Define SPI_READBACK_EN to add the miso capture path and the rx_data output.
module spi_master_arbiter #(
    parameter int CLK_DIV  = 2,
    parameter int CS_SETUP = 1,
    parameter int CS_HOLD  = 1,
    parameter int CS_IDLE  = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0,
    input  logic [6:0] data0,
    input  logic       req1,
    input  logic [6:0] data1,
    output logic       ack0,
    output logic       ack1,
    output logic       busy,
    output logic       sclk,
    output logic       mosi,
`ifdef SPI_READBACK_EN
    input  logic       miso,
    output logic [7:0] rx_data,
`endif
    output logic       chip_select
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_SHIFT,
        S_HOLD,
        S_GAP
    } state_t;

    localparam logic [15:0] DIV_M1   = 16'(CLK_DIV - 1);
    localparam logic [15:0] SETUP_M1 = 16'(CS_SETUP - 1);
    localparam logic [15:0] HOLD_M1  = 16'(CS_HOLD - 1);
    localparam logic [15:0] IDLE_M1  = 16'(CS_IDLE - 1);

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [3:0]  hp_q, hp_d;
    logic [7:0]  shift_q, shift_d;
    logic        sclk_q, sclk_d;
    logic        mosi_q, mosi_d;
    logic        cs_q, cs_d;
    logic        busy_q, busy_d;
    logic        ack0_q, ack0_d;
    logic        ack1_q, ack1_d;
    logic        last_q, last_d;
    logic        gnt_q, gnt_d;
    logic        pick;
`ifdef SPI_READBACK_EN
    logic [7:0]  cap_q, cap_d;
    logic [7:0]  rx_q, rx_d;
`endif

    // On a tie the requester that did not win last time gets the link.
    assign pick = (req0 && req1) ? ~last_q : req1;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hp_d    = hp_q;
        shift_d = shift_q;
        sclk_d  = sclk_q;
        mosi_d  = mosi_q;
        cs_d    = cs_q;
        busy_d  = busy_q;
        ack0_d  = 1'b0;
        ack1_d  = 1'b0;
        last_d  = last_q;
        gnt_d   = gnt_q;
`ifdef SPI_READBACK_EN
        cap_d   = cap_q;
        rx_d    = rx_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (req0 || req1) begin
                    gnt_d   = pick;
                    last_d  = pick;
                    shift_d = {pick, pick ? data1 : data0};
                    cs_d    = 1'b0;
                    busy_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = S_SETUP;
                end
            end
            S_SETUP: begin
                if (cnt_q == SETUP_M1) begin
                    cnt_d   = '0;
                    hp_d    = '0;
                    sclk_d  = 1'b1;
                    mosi_d  = shift_q[7];
                    state_d = S_SHIFT;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_SHIFT: begin
                if (cnt_q == DIV_M1) begin
                    cnt_d = '0;
                    hp_d  = hp_q + 4'd1;
                    // The 16th half-period is the low phase after the last falling edge.
                    if (hp_q == 4'd15) begin
                        state_d = S_HOLD;
                    end else if (sclk_q) begin
                        sclk_d = 1'b0;
`ifdef SPI_READBACK_EN
                        cap_d  = {cap_q[6:0], miso};
`endif
                    end else begin
                        sclk_d  = 1'b1;
                        mosi_d  = shift_q[6];
                        shift_d = {shift_q[6:0], 1'b0};
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_HOLD: begin
                if (cnt_q == HOLD_M1) begin
                    cnt_d   = '0;
                    cs_d    = 1'b1;
                    mosi_d  = 1'b0;
                    ack0_d  = ~gnt_q;
                    ack1_d  = gnt_q;
`ifdef SPI_READBACK_EN
                    rx_d    = cap_q;
`endif
                    state_d = S_GAP;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_GAP: begin
                if (cnt_q == IDLE_M1) begin
                    cnt_d   = '0;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
                cs_d    = 1'b1;
                sclk_d  = 1'b0;
                mosi_d  = 1'b0;
                busy_d  = 1'b0;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            hp_q    <= '0;
            shift_q <= '0;
            sclk_q  <= 1'b0;
            mosi_q  <= 1'b0;
            cs_q    <= 1'b1;
            busy_q  <= 1'b0;
            ack0_q  <= 1'b0;
            ack1_q  <= 1'b0;
            last_q  <= 1'b1;
            gnt_q   <= 1'b0;
`ifdef SPI_READBACK_EN
            cap_q   <= '0;
            rx_q    <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hp_q    <= hp_d;
            shift_q <= shift_d;
            sclk_q  <= sclk_d;
            mosi_q  <= mosi_d;
            cs_q    <= cs_d;
            busy_q  <= busy_d;
            ack0_q  <= ack0_d;
            ack1_q  <= ack1_d;
            last_q  <= last_d;
            gnt_q   <= gnt_d;
`ifdef SPI_READBACK_EN
            cap_q   <= cap_d;
            rx_q    <= rx_d;
`endif
        end
    end

    assign ack0        = ack0_q;
    assign ack1        = ack1_q;
    assign busy        = busy_q;
    assign sclk        = sclk_q;
    assign mosi        = mosi_q;
    assign chip_select = cs_q;
`ifdef SPI_READBACK_EN
    assign rx_data     = rx_q;
`endif

endmodule

// File: tb/tb_spi_master_arbiter.sv
// Bench for spi_master_arbiter: default instance plus a CLK_DIV=3/CS_SETUP=2 instance,
// each frame compared cycle by cycle against a waveform model built from the frame timing rules.
module tb_spi_master_arbiter;

    localparam int A_DIV = 2, A_SU = 1;
    localparam int B_DIV = 3, B_SU = 2;
    localparam int HOLD_C = 1, IDLE_C = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       req0, req1;
    logic [6:0] data0, data1;
    logic       sel;

    logic a_req0, a_req1, b_req0, b_req1;
    assign a_req0 = req0 & ~sel;
    assign a_req1 = req1 & ~sel;
    assign b_req0 = req0 & sel;
    assign b_req1 = req1 & sel;

    logic a_ack0, a_ack1, a_busy, a_sclk, a_mosi, a_cs;
    logic b_ack0, b_ack1, b_busy, b_sclk, b_mosi, b_cs;
`ifdef SPI_READBACK_EN
    logic       miso = 1'b0;
    logic [7:0] a_rx, b_rx, o_rx;
    assign o_rx = sel ? b_rx : a_rx;
`endif

    spi_master_arbiter #(.CLK_DIV(A_DIV), .CS_SETUP(A_SU), .CS_HOLD(HOLD_C), .CS_IDLE(IDLE_C)) u_dut_a (
        .clk(clk), .rst(rst), .req0(a_req0), .data0(data0), .req1(a_req1), .data1(data1),
        .ack0(a_ack0), .ack1(a_ack1), .busy(a_busy), .sclk(a_sclk), .mosi(a_mosi),
`ifdef SPI_READBACK_EN
        .miso(miso), .rx_data(a_rx),
`endif
        .chip_select(a_cs)
    );

    spi_master_arbiter #(.CLK_DIV(B_DIV), .CS_SETUP(B_SU), .CS_HOLD(HOLD_C), .CS_IDLE(IDLE_C)) u_dut_b (
        .clk(clk), .rst(rst), .req0(b_req0), .data0(data0), .req1(b_req1), .data1(data1),
        .ack0(b_ack0), .ack1(b_ack1), .busy(b_busy), .sclk(b_sclk), .mosi(b_mosi),
`ifdef SPI_READBACK_EN
        .miso(miso), .rx_data(b_rx),
`endif
        .chip_select(b_cs)
    );

    logic [5:0] obs;
    assign obs = sel ? {b_cs, b_sclk, b_mosi, b_busy, b_ack0, b_ack1}
                     : {a_cs, a_sclk, a_mosi, a_busy, a_ack0, a_ack1};

    int         tests = 0;
    int         fails = 0;
    int         last_g;
    logic [7:0] rx_pat;

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        tests++;
        assert (o === e) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
        end
    endtask

    // Expected {cs, sclk, mosi, busy, ack0, ack1} t cycles after the grant edge.
    function automatic logic [5:0] exp_vec(input int t, input int g, input logic [6:0] d,
                                           input int div, input int su);
        int         sh_end, tack, k;
        logic [7:0] w;
        logic       cs_e, sclk_e, mosi_e, busy_e;
        sh_end = su + 16 * div;
        tack   = sh_end + HOLD_C;
        w      = {(g != 0), d};
        cs_e   = (t >= tack);
        sclk_e = 1'b0;
        mosi_e = 1'b0;
        if (t >= su && t < sh_end) sclk_e = (((t - su) / div) % 2) == 0;
        if (t >= su && t < tack) begin
            k = ((t - su) / div) / 2;
            if (k > 7) k = 7;
            mosi_e = w[7-k];
        end
        busy_e = (t < tack + IDLE_C);
        return {cs_e, sclk_e, mosi_e, busy_e, (t == tack) && (g == 0), (t == tack) && (g == 1)};
    endfunction

    task automatic wait_grant(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            if (obs[5] === 1'b0) ok = 1'b1;
        end
        chk("grant_seen", ok, 1);
    endtask

    // Predicts the winner from the current requests, then checks the whole frame and gap.
    task automatic expect_frame(input bit keep, input bit drop_mid, input bit scramble);
        int         g, div, su, tack, tend, j;
        logic [6:0] d;
        bit         ok;
        div = sel ? B_DIV : A_DIV;
        su  = sel ? B_SU : A_SU;
        g   = (req0 && req1) ? 1 - last_g : (req1 ? 1 : 0);
        d   = (g == 1) ? data1 : data0;
        wait_grant(ok);
        if (!ok) return;
        last_g = g;
        tack = su + 16 * div + HOLD_C;
        tend = tack + IDLE_C;
        for (int t = 0; t <= tend; t++) begin
            if (t > 0) @(negedge clk);
            chk($sformatf("frame g=%0d d=%0h t=%0d", g, d, t), obs, exp_vec(t, g, d, div, su));
`ifdef SPI_READBACK_EN
            j = (t < su + div) ? 0 : ((t - su) / div + 1) / 2;
            if (j < 8) miso = rx_pat[7-j];
            if (t == tack) chk("rx_data", o_rx, rx_pat);
`else
            j = 0;
`endif
            if (t == 3 && scramble) begin
                data0 = 7'($urandom);
                data1 = 7'($urandom);
            end
            if ((t == 5 && drop_mid) || (t == tack && !keep)) begin
                if (g == 0) req0 = 1'b0;
                else req1 = 1'b0;
            end
        end
    endtask

    initial begin
        bit ok;
        int falls;
        logic prev;
        rst = 1'b0; req0 = 1'b0; req1 = 1'b0; data0 = '0; data1 = '0; sel = 1'b0;
        last_g = 1;
        rx_pat = 8'hA3;
        @(negedge clk);
        chk("reset_outputs", obs, 6'b100000);
        @(negedge clk);
        rst = 1'b1;

        // Single write
        req0 = 1'b1; data0 = 7'h55;
        expect_frame(1'b0, 1'b0, 1'b0);

        // Tie after reset, then fairness with both held
        req0 = 1'b1; req1 = 1'b1; data0 = 7'h7F; data1 = 7'h01; rx_pat = 8'h5C;
        expect_frame(1'b0, 1'b0, 1'b0);
        expect_frame(1'b0, 1'b0, 1'b0);
        req0 = 1'b1; req1 = 1'b1;
        for (int n = 0; n < 4; n++) begin
            rx_pat = 8'($urandom);
            expect_frame(1'b1, 1'b0, 1'b0);
        end
        req0 = 1'b0; req1 = 1'b0;

        // Random traffic
        for (int n = 0; n < 10; n++) begin
            if (!req0 && $urandom_range(0, 1) == 1) begin req0 = 1'b1; data0 = 7'($urandom); end
            if (!req1 && $urandom_range(0, 1) == 1) begin req1 = 1'b1; data1 = 7'($urandom); end
            if (!req0 && !req1) begin req0 = 1'b1; data0 = 7'($urandom); end
            rx_pat = 8'($urandom);
            expect_frame(1'b0, $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1);
        end
        req0 = 1'b0; req1 = 1'b0;

        // Reset at the 4th falling sclk edge
        @(negedge clk);
        req0 = 1'b1; data0 = 7'($urandom);
        wait_grant(ok);
        falls = 0;
        prev = obs[4];
        for (int i = 0; i < 200 && falls < 4; i++) begin
            @(negedge clk);
            if (prev && !obs[4]) falls++;
            prev = obs[4];
        end
        chk("midreset_falls", falls, 4);
        rst = 1'b0;
        req0 = 1'b0;
        #1;
        chk("midreset_outputs", obs, 6'b100000);
        last_g = 1;
        @(negedge clk);
        chk("midreset_held", obs, 6'b100000);
        rst = 1'b1;
        req1 = 1'b1; data1 = 7'($urandom); rx_pat = 8'($urandom);
        expect_frame(1'b0, 1'b0, 1'b0);

        // Slow instance: CLK_DIV=3, CS_SETUP=2
        sel = 1'b1;
        last_g = 1;
        @(negedge clk);
        req0 = 1'b1; data0 = 7'($urandom); rx_pat = 8'hA3;
        expect_frame(1'b0, 1'b0, 1'b0);
        req0 = 1'b1; req1 = 1'b1; data0 = 7'($urandom); data1 = 7'($urandom);
        rx_pat = 8'($urandom);
        expect_frame(1'b0, 1'b0, 1'b1);
        rx_pat = 8'($urandom);
        expect_frame(1'b0, 1'b0, 1'b0);
        req0 = 1'b0; req1 = 1'b0;
        @(negedge clk);
        chk("final_idle", obs, 6'b100000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
